// File: rtl/dense_pkg.sv
// Shared types and constants for the dense neuron: FSM states, activation
// encodings, sigmoid clamp limits and the Q8.8 sigmoid table (N=16, Q=8).
package dense_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Encoding 2'd3 is not listed and behaves as identity.
  typedef enum logic [1:0] {
    ACT_NONE    = 2'd0,
    ACT_RELU    = 2'd1,
    ACT_SIGMOID = 2'd2
  } act_e;

  localparam int SIG_LUT_DEPTH = 256;
  localparam int SIG_CLAMP_HI  = 2048;
  localparam int SIG_CLAMP_LO  = -2048;
  localparam logic [15:0] SIG_ONE = 16'd256;

  // Entry i = round(256 / (1 + exp(-(16*i - 2048)/256))).
  localparam logic [15:0] SIG_LUT [SIG_LUT_DEPTH] = '{
    16'd0,   16'd0,   16'd0,   16'd0,   16'd0,   16'd0,   16'd0,   16'd0,   16'd0,   16'd0,   16'd0,   16'd0,   16'd0,   16'd0,   16'd0,   16'd0,
    16'd0,   16'd0,   16'd0,   16'd0,   16'd0,   16'd0,   16'd0,   16'd0,   16'd0,   16'd0,   16'd0,   16'd0,   16'd0,   16'd1,   16'd1,   16'd1,
    16'd1,   16'd1,   16'd1,   16'd1,   16'd1,   16'd1,   16'd1,   16'd1,   16'd1,   16'd1,   16'd1,   16'd1,   16'd1,   16'd1,   16'd2,   16'd2,
    16'd2,   16'd2,   16'd2,   16'd2,   16'd2,   16'd2,   16'd2,   16'd3,   16'd3,   16'd3,   16'd3,   16'd3,   16'd4,   16'd4,   16'd4,   16'd4,
    16'd5,   16'd5,   16'd5,   16'd6,   16'd6,   16'd6,   16'd7,   16'd7,   16'd8,   16'd8,   16'd8,   16'd9,   16'd10,  16'd10,  16'd11,  16'd11,
    16'd12,  16'd13,  16'd14,  16'd15,  16'd15,  16'd16,  16'd17,  16'd18,  16'd19,  16'd21,  16'd22,  16'd23,  16'd24,  16'd26,  16'd27,  16'd29,
    16'd31,  16'd32,  16'd34,  16'd36,  16'd38,  16'd40,  16'd42,  16'd44,  16'd47,  16'd49,  16'd52,  16'd54,  16'd57,  16'd60,  16'd63,  16'd66,
    16'd69,  16'd72,  16'd75,  16'd79,  16'd82,  16'd86,  16'd89,  16'd93,  16'd97,  16'd100, 16'd104, 16'd108, 16'd112, 16'd116, 16'd120, 16'd124,
    16'd128, 16'd132, 16'd136, 16'd140, 16'd144, 16'd148, 16'd152, 16'd156, 16'd159, 16'd163, 16'd167, 16'd170, 16'd174, 16'd177, 16'd181, 16'd184,
    16'd187, 16'd190, 16'd193, 16'd196, 16'd199, 16'd202, 16'd204, 16'd207, 16'd209, 16'd212, 16'd214, 16'd216, 16'd218, 16'd220, 16'd222, 16'd224,
    16'd225, 16'd227, 16'd229, 16'd230, 16'd232, 16'd233, 16'd234, 16'd235, 16'd237, 16'd238, 16'd239, 16'd240, 16'd241, 16'd241, 16'd242, 16'd243,
    16'd244, 16'd245, 16'd245, 16'd246, 16'd246, 16'd247, 16'd248, 16'd248, 16'd248, 16'd249, 16'd249, 16'd250, 16'd250, 16'd250, 16'd251, 16'd251,
    16'd251, 16'd252, 16'd252, 16'd252, 16'd252, 16'd253, 16'd253, 16'd253, 16'd253, 16'd253, 16'd254, 16'd254, 16'd254, 16'd254, 16'd254, 16'd254,
    16'd254, 16'd254, 16'd254, 16'd255, 16'd255, 16'd255, 16'd255, 16'd255, 16'd255, 16'd255, 16'd255, 16'd255, 16'd255, 16'd255, 16'd255, 16'd255,
    16'd255, 16'd255, 16'd255, 16'd255, 16'd256, 16'd256, 16'd256, 16'd256, 16'd256, 16'd256, 16'd256, 16'd256, 16'd256, 16'd256, 16'd256, 16'd256,
    16'd256, 16'd256, 16'd256, 16'd256, 16'd256, 16'd256, 16'd256, 16'd256, 16'd256, 16'd256, 16'd256, 16'd256, 16'd256, 16'd256, 16'd256, 16'd256
  };

endpackage

// File: rtl/dense_act_neuron_sigmoid_rom.sv
// Combinational sigmoid lookup: clamps the Q8.8 input to (-8.0, 8.0) and
// indexes the 256-entry table in steps of 1/16.
module sigmoid_rom
  import dense_pkg::*;
#(
  parameter int N = 16
) (
  input  logic signed [N-1:0] val_i,
  output logic        [N-1:0] val_o
);

  logic [7:0] idx_s;

  // (val + 2048) >> 4 equals val[11:4] + 128 because 2048 is a multiple of 16.
  always_comb begin
    idx_s = val_i[11:4] + 8'd128;
    if (val_i <= SIG_CLAMP_LO) begin
      val_o = {N{1'b0}};
    end else if (val_i >= SIG_CLAMP_HI) begin
      val_o = N'(SIG_ONE);
    end else begin
      val_o = N'(SIG_LUT[idx_s]);
    end
  end

endmodule

// File: rtl/dense_act_neuron.sv
// Single dense neuron: sequential MAC over NUM_INPUTS lanes, then saturation
// and a selectable activation (identity / ReLU / sigmoid LUT).
// Optional build macro DENSE_ROUND_EN: round half up before the final >>> Q.
module dense_act_neuron
  import dense_pkg::*;
#(
  parameter int N          = 16,
  parameter int Q          = 8,
  parameter int NUM_INPUTS = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              act_sel,
  input  logic [NUM_INPUTS*N-1:0] input_vec,
  input  logic [NUM_INPUTS*N-1:0] weight_vec,
  input  logic [N-1:0]            bias,
  output logic                    busy,
  output logic [N-1:0]            raw_val,
  output logic [N-1:0]            output_val,
  output logic                    done
);

  // Wide enough that NUM_INPUTS full products plus the bias never overflow.
  localparam int AW = 2*N + $clog2(NUM_INPUTS) + 1;
  localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_INPUTS - 1);
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-N+1){1'b1}}, {(N-1){1'b0}}};
  localparam logic signed [AW-1:0] RND_HALF = {{(AW-1){1'b0}}, 1'b1} << (Q-1);

  state_e                    state_q, state_d;
  logic [NUM_INPUTS*N-1:0]   x_q, x_d, w_q, w_d;
  logic [1:0]                act_q, act_d;
  logic signed [AW-1:0]      acc_q, acc_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      busy_q, busy_d, done_q, done_d;
  logic [N-1:0]              raw_q, raw_d, out_q, out_d;

  logic signed [N-1:0]       x_cur_s, w_cur_s, r_sat_s;
  logic signed [2*N-1:0]     prod_s;
  logic signed [AW-1:0]      bias_ext_s, acc_adj_s, shr_s;
  logic [N-1:0]              sig_s, act_s;

  assign x_cur_s    = x_q[idx_q*N +: N];
  assign w_cur_s    = w_q[idx_q*N +: N];
  assign prod_s     = x_cur_s * w_cur_s;
  assign bias_ext_s = {{(AW-N){bias[N-1]}}, bias};

  sigmoid_rom #(.N(N)) u_sigmoid_rom (
    .val_i (r_sat_s),
    .val_o (sig_s)
  );

  // Scale the accumulator back to Q format, saturate to N bits, then activate.
  always_comb begin
`ifdef DENSE_ROUND_EN
    acc_adj_s = acc_q + RND_HALF;
`else
    acc_adj_s = acc_q;
`endif
    shr_s = acc_adj_s >>> Q;
    if (shr_s > SAT_MAX) begin
      r_sat_s = SAT_MAX[N-1:0];
    end else if (shr_s < SAT_MIN) begin
      r_sat_s = SAT_MIN[N-1:0];
    end else begin
      r_sat_s = shr_s[N-1:0];
    end
    case (act_q)
      ACT_RELU:    act_s = r_sat_s[N-1] ? {N{1'b0}} : r_sat_s;
      ACT_SIGMOID: act_s = sig_s;
      default:     act_s = r_sat_s;
    endcase
  end

  // Next-state logic: accept in IDLE, one MAC per cycle, publish in OUT.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    w_d     = w_q;
    act_d   = act_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    raw_d   = raw_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d     = input_vec;
          w_d     = weight_vec;
          act_d   = act_sel;
          acc_d   = bias_ext_s <<< Q;
          idx_d   = {IW{1'b0}};
          busy_d  = 1'b1;
          state_d = ST_MAC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + prod_s;
        if (idx_q == IDX_LAST) begin
          state_d = ST_OUT;
        end else begin
          idx_d = idx_q + IW'(1'b1);
        end
      end
      ST_OUT: begin
        raw_d   = r_sat_s;
        out_d   = act_s;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      x_q     <= {(NUM_INPUTS*N){1'b0}};
      w_q     <= {(NUM_INPUTS*N){1'b0}};
      act_q   <= 2'd0;
      acc_q   <= {AW{1'b0}};
      idx_q   <= {IW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      raw_q   <= {N{1'b0}};
      out_q   <= {N{1'b0}};
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      w_q     <= w_d;
      act_q   <= act_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      raw_q   <= raw_d;
      out_q   <= out_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign raw_val    = raw_q;
  assign output_val = out_q;

endmodule

// File: tb/tb_dense_act_neuron.sv
// Self-checking bench for dense_act_neuron (NUM_INPUTS=4, Q8.8): directed
// cases plus randomized operations compared against a real-arithmetic model.
module tb_dense_act_neuron;

  localparam int NI = 4;
  localparam int NB = 16;

  logic            clk;
  logic            reset_n;
  logic            start;
  logic [1:0]      act_sel;
  logic [NI*NB-1:0] input_vec;
  logic [NI*NB-1:0] weight_vec;
  logic [NB-1:0]   bias;
  logic            busy;
  logic [NB-1:0]   raw_val;
  logic [NB-1:0]   output_val;
  logic            done;

  int n_checks = 0;
  int n_fail   = 0;

  dense_act_neuron #(.N(NB), .Q(8), .NUM_INPUTS(NI)) dut (
    .clk        (clk),
    .reset      (reset_n),
    .start      (start),
    .act_sel    (act_sel),
    .input_vec  (input_vec),
    .weight_vec (weight_vec),
    .bias       (bias),
    .busy       (busy),
    .raw_val    (raw_val),
    .output_val (output_val),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case some wait is never satisfied.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rep4(input logic [15:0] v);
    return {v, v, v, v};
  endfunction

  // Reference: exact dot product in integers, scale with real floor, clamp, activate.
  function automatic void model(input logic [63:0] xv, input logic [63:0] wv,
                                input logic [15:0] b, input logic [1:0] a,
                                output longint raw, output longint act);
    longint sum;
    real    rr;
    real    xr;
    longint idx;
    sum = longint'($signed(b)) * 256;
    for (int i = 0; i < NI; i++)
      sum += longint'($signed(xv[i*16 +: 16])) * longint'($signed(wv[i*16 +: 16]));
`ifdef DENSE_ROUND_EN
    rr = $floor(real'(sum) / 256.0 + 0.5);
`else
    rr = $floor(real'(sum) / 256.0);
`endif
    raw = longint'(rr);
    if (raw > 32767) raw = 32767;
    if (raw < -32768) raw = -32768;
    if (a == 2'd1) begin
      act = (raw < 0) ? 0 : raw;
    end else if (a == 2'd2) begin
      if (raw <= -2048) act = 0;
      else if (raw >= 2048) act = 256;
      else begin
        idx = (raw + 2048) / 16;
        xr  = real'(16 * idx - 2048) / 256.0;
        act = longint'($floor(256.0 / (1.0 + $exp(-xr)) + 0.5));
      end
    end else begin
      act = raw;
    end
  endfunction

  // One operation: pulse start, scramble inputs, check busy, latency and results.
  task automatic do_op(input string tag, input logic [63:0] xv, input logic [63:0] wv,
                       input logic [15:0] b, input logic [1:0] a,
                       output longint got_raw, output longint got_out);
    longint e_raw, e_out;
    int     cyc;
    model(xv, wv, b, a, e_raw, e_out);
    @(negedge clk);
    input_vec = xv; weight_vec = wv; bias = b; act_sel = a; start = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    input_vec  = {$urandom(), $urandom()};
    weight_vec = {$urandom(), $urandom()};
    bias       = 16'($urandom());
    act_sel    = 2'($urandom());
    check_val({tag, "_busy_accept"}, longint'(busy), 1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (done !== 1'b1) check_val({tag, "_busy_mid"}, longint'(busy), 1);
    end
    check_val({tag, "_latency"}, longint'(cyc), NI + 1);
    check_val({tag, "_busy_done"}, longint'(busy), 0);
    got_raw = longint'($signed(raw_val));
    got_out = longint'($signed(output_val));
    check_val({tag, "_raw"}, got_raw, e_raw);
    check_val({tag, "_out"}, got_out, e_out);
  endtask

  initial begin
    longint r, o, r0;
    int     n_done;
    logic [63:0] xv, wv;
    int     mode, t;

    reset_n = 1'b0; start = 1'b0; act_sel = 2'd0;
    input_vec = 64'd0; weight_vec = 64'd0; bias = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", longint'(busy), 0);
    check_val("rst_done", longint'(done), 0);
    check_val("rst_raw", longint'(raw_val), 0);
    check_val("rst_out", longint'(output_val), 0);
    @(negedge clk); reset_n = 1'b1;

    // ReLU on a positive sum
    do_op("relu_pos", rep4(16'd256), rep4(16'd128), 16'd64, 2'd1, r, o);
    check_val("relu_pos_raw_lit", r, 576);
    check_val("relu_pos_out_lit", o, 576);
    @(posedge clk); #1;
    check_val("done_one_cycle", longint'(done), 0);
    check_val("raw_hold", longint'($signed(raw_val)), 576);

    // Negative sum: ReLU clips, identity passes
    do_op("relu_neg", rep4(16'd256), rep4(16'hFF80), 16'd64, 2'd1, r, o);
    check_val("relu_neg_raw_lit", r, -448);
    check_val("relu_neg_out_lit", o, 0);
    do_op("ident_neg", rep4(16'd256), rep4(16'hFF80), 16'd64, 2'd0, r, o);
    check_val("ident_neg_out_lit", o, -448);

    // Sigmoid centre, mid-table and both clamps
    do_op("sig_zero", 64'd0, rep4(16'd77), 16'd0, 2'd2, r, o);
    check_val("sig_zero_lit", o, 128);
    do_op("sig_four", 64'd0, 64'd0, 16'd1024, 2'd2, r, o);
    check_val("sig_four_lit", o, 251);
    do_op("sig_hi", 64'd0, 64'd0, 16'd4096, 2'd2, r, o);
    check_val("sig_hi_lit", o, 256);
    do_op("sig_lo", 64'd0, 64'd0, 16'hF000, 2'd2, r, o);
    check_val("sig_lo_lit", o, 0);

    // Saturation both ways
    do_op("sat_pos", rep4(16'h7FFF), rep4(16'h7FFF), 16'h7FFF, 2'd0, r, o);
    check_val("sat_pos_lit", r, 32767);
    do_op("sat_neg", rep4(16'h7FFF), rep4(16'h8000), 16'h7FFF, 2'd0, r, o);
    check_val("sat_neg_lit", r, -32768);

    // Rounding of an exact half LSB
    do_op("round", 64'd1, 64'd128, 16'd0, 2'd0, r, o);
`ifdef DENSE_ROUND_EN
    check_val("round_lit", r, 1);
`else
    check_val("round_lit", r, 0);
`endif

    // Start while busy is ignored: one done carrying the first result
    @(negedge clk);
    input_vec = rep4(16'd256); weight_vec = rep4(16'd128); bias = 16'd64; act_sel = 2'd0;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    input_vec = rep4(16'd512); weight_vec = rep4(16'd512); bias = 16'd0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n_done = 0; r0 = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        n_done++;
        r0 = longint'($signed(raw_val));
      end
    end
    check_val("busy_start_dones", longint'(n_done), 1);
    check_val("busy_start_raw", r0, 576);

    // Back-to-back: the second start lands in the done cycle
    do_op("b2b_a", rep4(16'd256), rep4(16'd128), 16'd64, 2'd1, r, o);
    do_op("b2b_b", rep4(16'd256), rep4(16'hFF80), 16'd64, 2'd0, r, o);

    // Reset during MAC aborts immediately
    @(negedge clk);
    input_vec = rep4(16'd300); weight_vec = rep4(16'd100); bias = 16'd5; act_sel = 2'd0;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check_val("abort_busy", longint'(busy), 0);
    check_val("abort_raw", longint'(raw_val), 0);
    check_val("abort_out", longint'(output_val), 0);
    @(negedge clk); reset_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) n_done++;
    end
    check_val("abort_no_done", longint'(n_done), 0);
    do_op("after_abort", rep4(16'd256), rep4(16'd128), 16'd64, 2'd1, r, o);
    check_val("after_abort_lit", r, 576);

    // Randomized operations
    for (int k = 0; k < 40; k++) begin
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < NI; i++) begin
        if (mode == 0) begin
          t = int'($urandom_range(0, 511)) - 256; xv[i*16 +: 16] = 16'(t);
          t = int'($urandom_range(0, 511)) - 256; wv[i*16 +: 16] = 16'(t);
        end else if (mode == 1) begin
          xv[i*16 +: 16] = 16'($urandom()); wv[i*16 +: 16] = 16'($urandom());
        end else begin
          t = int'($urandom_range(0, 127)) - 64; xv[i*16 +: 16] = 16'(t);
          t = int'($urandom_range(0, 127)) - 64; wv[i*16 +: 16] = 16'(t);
        end
      end
      t = int'($urandom_range(0, 8191)) - 4096;
      do_op("rand", xv, wv, 16'(t), 2'($urandom_range(0, 3)), r, o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dense_act_neuron.md
Name: dense_act_neuron

Overview:
- Single fully-connected neuron with fused activation.
- Computes y = act(sum(x[i]*w[i]) + b) over NUM_INPUTS signed fixed-point operands using one sequential multiply-accumulate (MAC) step per cycle.
- act is selectable per start: identity, ReLU, or sigmoid lookup table (LUT).
- Sits under the inference FSM, which time-multiplexes it across the neurons of each dense layer.

Parameters:
- N, 16, operand/result width, signed two's complement.
- Q, 8, fractional bits (Q8.8 by default).
- NUM_INPUTS, 16, vector length; must be at least 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- act_sel  in  2  activation select: 0 identity, 1 ReLU, 2 sigmoid, 3 identity.
- input_vec  in  NUM_INPUTS*N  packed x; element i at bits [i*N +: N].
- weight_vec  in  NUM_INPUTS*N  packed w, same layout.
- bias  in  N  bias in Q format.
- busy  out  1  high from accept until done.
- raw_val  out  N  saturated pre-activation result.
- output_val  out  N  activated result.
- done  out  1  one-cycle pulse when both results are valid.

Behaviour:
- States: IDLE, MAC, OUT.
- Reset (reset=0, asynchronous): state IDLE; busy, done, raw_val, output_val, accumulator and index all 0.
- IDLE, on start=1:
  - Register input_vec, weight_vec, bias and act_sel.
  - acc <= sign-extended bias << Q; idx <= 0; busy <= 1; go to MAC.
  - Inputs may change after acceptance without effect.
- MAC: acc += x[idx]*w[idx], with a full 2N-bit signed product each cycle. After idx = NUM_INPUTS-1, go to OUT.
- Accumulator width: 2N + clog2(NUM_INPUTS) + 1; no internal overflow.
- OUT:
  - r = acc >>> Q (arithmetic shift, truncation).
  - Saturate r to [-2^(N-1), 2^(N-1)-1]; raw_val <= r.
  - output_val <= act(r); done <= 1 for exactly one cycle; busy <= 0; return to IDLE.
- Latency: start sampled at edge k; done is high in the cycle after edge k+NUM_INPUTS+1. Back-to-back start is legal in the cycle done is high, since the state is IDLE then.
- raw_val and output_val hold until the next OUT.
- start while busy: ignored; no queuing.
- ReLU: r<0 gives 0, else r.
- Sigmoid LUT: 256 entries.
  - Entry i maps to x_i = (16*i - 2048)/256 real and holds round(2^Q / (1 + e^(-x_i))).
  - Input clamping: if r <= -2048, output 0; if r >= 2048, output 256 (1.0).
  - Otherwise index = (r + 2048) >> 4.
  - Output range is [0, 2^Q].
- Reset mid-operation aborts immediately: no done pulse and outputs return to 0.

Optional Feature:
- Macro DENSE_ROUND_EN.
- Defined: OUT adds 1 << (Q-1) to acc before the >>> Q (round half up), then saturates.
- Undefined: plain arithmetic-shift truncation.
- The LUT is unaffected either way.

Decomposition:
- Package dense_pkg holds:
  - act_sel encodings as an enum (ACT_NONE, ACT_RELU, ACT_SIGMOID).
  - The state enum.
  - SIG_LUT_DEPTH = 256 and the clamp limits ±2048.
  - The precomputed 256-entry sigmoid constant array, for Q=8 and N=16.
- Sub-module sigmoid_rom: purely combinational, N-bit input to N-bit output; implements the clamp, indexing and table.
- ReLU and saturation stay inline.

Test Plan:
All scenarios use NUM_INPUTS=4, Q=8.
- x all 256, w all 128, bias 64, act=1 → raw_val 576 and output_val 576; done exactly 6 cycles after the start edge; busy high in between.
- x all 256, w all -128, bias 64, act=1 → raw_val -448, output_val 0. Same inputs with act=0 → output_val -448.
- x all 0, bias 0, act=2 → output_val 128. Bias 1024 (4.0), act=2 → output_val 251. Bias 4096, act=2 → 256. Bias -4096, act=2 → 0.
- x and w all 0x7FFF, bias 0x7FFF, act=0 → raw_val 0x7FFF (saturated). w all 0x8000 with the same x → raw_val 0x8000.
- Second start pulsed two cycles after the first → ignored; exactly one done. A start in the done cycle → a second done 6 cycles later.
- reset driven low during MAC → outputs 0 immediately and no done. After release, a new start produces the correct result.
- Rounding checks with one nonzero lane (x=1, w=128, bias 0; exact result 0.5 LSB):
  - With DENSE_ROUND_EN → raw_val 1.
  - Without it → raw_val 0.
